useq_issue: RTL



---
 rtl/useq_issue.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/useq_issue.sv
// Micro-operation issue sequencer: fetch, decode, one- or two-step execute with ready-gated commits.
// Optional single-step hold after each retire is enabled by defining USEQ_STEP_EN.
module useq_issue #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             mem_rdy,
  input  logic             io_rdy,
`ifdef USEQ_STEP_EN
  input  logic             step,
`endif
  output logic [2:0]       m2,
  output logic             en,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] icnt
);

`ifdef USEQ_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_HALT, S_STEP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC1, S_EXEC2, S_HALT
  } state_t;
`endif

  typedef enum logic [2:0] {
    U_NOP2 = 3'b000,
    U_IRM  = 3'b001,
    U_MRS  = 3'b010,
    U_RDM  = 3'b011,
    U_PLUS = 3'b100,
    U_MINU = 3'b101,
    U_RDIN = 3'b110,
    U_OTRS = 3'b111
  } uop_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LD   = 4'h1,
    OP_ST   = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_IN   = 4'h5,
    OP_OUT  = 4'h6,
    OP_ADDM = 4'h7,
    OP_HLT  = 4'hF
  } op_t;

  state_t state;
  op_t    ir;

  state_t     rt_state;
  logic [2:0] rt_m2;
  logic       rt_busy;

  function automatic uop_t exec_uop(input logic [3:0] op);
    case (op)
      OP_NOP:  return U_NOP2;
      OP_LD:   return U_RDM;
      OP_ST:   return U_MRS;
      OP_ADD:  return U_PLUS;
      OP_SUB:  return U_MINU;
      OP_IN:   return U_RDIN;
      OP_OUT:  return U_OTRS;
      OP_ADDM: return U_RDM;
      default: return U_NOP2;
    endcase
  endfunction

  function automatic logic is_gated(input logic [2:0] u);
    case (u)
      U_IRM, U_MRS, U_RDM, U_RDIN, U_OTRS: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic uop_ready(input logic [2:0] u, input logic mr, input logic ir_rdy);
    case (u)
      U_IRM, U_MRS, U_RDM: return mr;
      U_RDIN, U_OTRS:      return ir_rdy;
      default:             return 1'b1;
    endcase
  endfunction

  // Destination after the last execute commit; shared by EXEC1 and EXEC2.
  always_comb begin
`ifdef USEQ_STEP_EN
    rt_state = S_STEP;
    rt_m2    = U_NOP2;
    rt_busy  = 1'b1;
`else
    if (run) begin
      rt_state = S_FETCH;
      rt_m2    = U_IRM;
      rt_busy  = 1'b1;
    end else begin
      rt_state = S_IDLE;
      rt_m2    = U_NOP2;
      rt_busy  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ir      <= OP_NOP;
      m2      <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      icnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            m2    <= U_IRM;
            busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          if (en) begin
            en    <= 1'b0;
            state <= S_DECODE;
            m2    <= U_NOP2;
          end else if (mem_rdy) begin
            en <= 1'b1;
          end
        end

        // Execute outputs are registered here so ungated ops commit in their first cycle.
        S_DECODE: begin
          ir <= op_t'(opcode);
          if (opcode == OP_HLT) begin
            state  <= S_HALT;
            m2     <= U_NOP2;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_EXEC1;
            m2    <= exec_uop(opcode);
            en    <= !is_gated(exec_uop(opcode));
            if (opcode[3]) illegal <= 1'b1;
          end
        end

        S_EXEC1, S_EXEC2: begin
          if (en) begin
            if (state == S_EXEC1 && ir == OP_ADDM) begin
              state <= S_EXEC2;
              m2    <= U_PLUS;
              en    <= 1'b1;
            end else begin
              en    <= 1'b0;
              state <= rt_state;
              m2    <= rt_m2;
              busy  <= rt_busy;
              icnt  <= icnt + 1'b1;
            end
          end else if (uop_ready(m2, mem_rdy, io_rdy)) begin
            en <= 1'b1;
          end
        end

        S_HALT: begin
          m2 <= U_NOP2;
          en <= 1'b0;
        end

`ifdef USEQ_STEP_EN
        S_STEP: begin
          if (step) begin
            if (run) begin
              state <= S_FETCH;
              m2    <= U_IRM;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
        end
`endif

        default: begin
          state <= S_IDLE;
          m2    <= U_NOP2;
          en    <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
